mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_req_latch.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the kernel memory-port arbiter:
//   - default widths and the host wait limit
//   - the host "ready" completion value (only exactly 1 means done)
//   - FSM state encoding
//   - byte-address helper used for both host request channels
package mem_arb_pkg;

  localparam int ADDR_WID_DEF = 14;
  localparam int DATA_WID_DEF = 32;
  localparam int TIMEOUT_DEF  = 1024;

  localparam logic [63:0] READY_VALID = 64'd1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STEP    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_WAIT_RD = 3'd4;
  localparam logic [2:0] ST_WAIT_WR = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_HALT    = 3'd7;

  // Word address (already zero-extended) to host byte address, modulo 2^64.
  function automatic logic [63:0] byteAddr(input logic [63:0] base,
                                           input logic [63:0] wordAddr);
    return base + (wordAddr << 2);
  endfunction

endpackage

// File: rtl/mem_arb_req_latch.sv
// mem_arb_req_latch
// Holds one kernel BRAM port's request as seen in the CAPTURE cycle, plus the
// pending bit that stays set until the host transaction for it completes.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_capture    load ce/we/addr/d from the kernel port
//   i_clear      host transaction for this port finished
//   i_ce/i_we/i_addr/i_d   kernel port request
//   o_pending/o_we/o_addr/o_d   captured request
module mem_arb_req_latch
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int DATA_WID = DATA_WID_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_capture,
  input  logic                i_clear,
  input  logic                i_ce,
  input  logic                i_we,
  input  logic [ADDR_WID-1:0] i_addr,
  input  logic [DATA_WID-1:0] i_d,
  output logic                o_pending,
  output logic                o_we,
  output logic [ADDR_WID-1:0] o_addr,
  output logic [DATA_WID-1:0] o_d
);

  logic                r_pending;
  logic                r_we;
  logic [ADDR_WID-1:0] r_addr;
  logic [DATA_WID-1:0] r_d;

  // Capture has priority; capture and clear never coincide because clear
  // only happens in the WAIT states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_d       <= '0;
    end else if (i_capture) begin
      r_pending <= i_ce;
      r_we      <= i_we;
      r_addr    <= i_addr;
      r_d       <= i_d;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_d       = r_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Steps an HLS kernel one cycle at a time and turns each step's BRAM port
// accesses (two ports) into host read/write transactions, servicing port 0
// before port 1.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_start                    begin a run (IDLE only)
//   i_kernel_done              kernel ap_done, looked at in CAPTURE
//   o_kernel_en                one-cycle kernel step enable
//   i_req_ce/we/addr/d         per-port kernel requests (port p in slice p)
//   o_rsp_q                    per-port read data, held until next read
//   i_read_base/i_write_base   host byte base addresses
//   i_read_size_input          size copied to both request channels
//   o_read_enable/o_write_enable   one-cycle host request pulses
//   o_read_addr/o_write_addr/o_read_size_output/o_write_size/o_write_data
//   i_read_data, i_read_ready, i_write_ready   host completion (ready==1)
//   o_done                     one-cycle run-end pulse
//   o_err                      sticky host timeout flag
//   o_access_count             completed host transactions (saturating)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WID = ADDR_WID_DEF,
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_kernel_done,
  output logic                  o_kernel_en,
  input  logic [1:0]            i_req_ce,
  input  logic [1:0]            i_req_we,
  input  logic [2*ADDR_WID-1:0] i_req_addr,
  input  logic [2*DATA_WID-1:0] i_req_d,
  output logic [2*DATA_WID-1:0] o_rsp_q,
  input  logic [63:0]           i_read_base,
  input  logic [63:0]           i_write_base,
  input  logic [63:0]           i_read_size_input,
  output logic                  o_read_enable,
  output logic                  o_write_enable,
  output logic [63:0]           o_read_addr,
  output logic [63:0]           o_write_addr,
  output logic [63:0]           o_read_size_output,
  output logic [63:0]           o_write_size,
  output logic [DATA_WID-1:0]   o_write_data,
  input  logic [DATA_WID-1:0]   i_read_data,
  input  logic [63:0]           i_read_ready,
  input  logic [63:0]           i_write_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_access_count
);

  logic [2:0]            r_state;
  logic                  r_kdone;
  logic [31:0]           r_waitCnt;
  logic                  r_err;
  logic [31:0]           r_accessCount;
  logic [2*DATA_WID-1:0] r_rspQ;
  logic [63:0]           r_readAddr;
  logic [63:0]           r_readSize;
  logic [63:0]           r_writeAddr;
  logic [63:0]           r_writeSize;
  logic [DATA_WID-1:0]   r_writeData;

  logic [1:0]            w_pending;
  logic [1:0]            w_we;
  logic [ADDR_WID-1:0]   w_addr [2];
  logic [DATA_WID-1:0]   w_d [2];
  logic [1:0]            w_clear;
  logic                  w_capture;
  logic                  w_selPort;
  logic                  w_selWe;
  logic [63:0]           w_selAddr;
  logic                  w_issueRd;
  logic                  w_issueWr;
  logic                  w_complete;
  logic [1:0]            w_pendingLeft;

  assign w_capture = (r_state == ST_CAPTURE);

  for (genvar p = 0; p < 2; p++) begin : g_port
    mem_arb_req_latch #(
      .ADDR_WID (ADDR_WID),
      .DATA_WID (DATA_WID)
    ) u_latch (
      .clk       (clk),
      .reset     (reset),
      .i_capture (w_capture),
      .i_clear   (w_clear[p]),
      .i_ce      (i_req_ce[p]),
      .i_we      (i_req_we[p]),
      .i_addr    (i_req_addr[p*ADDR_WID +: ADDR_WID]),
      .i_d       (i_req_d[p*DATA_WID +: DATA_WID]),
      .o_pending (w_pending[p]),
      .o_we      (w_we[p]),
      .o_addr    (w_addr[p]),
      .o_d       (w_d[p])
    );
  end

  // Lowest pending port is the one being issued or waited on; its bit only
  // drops on completion, so the selection is stable across ISSUE and WAIT.
  assign w_selPort = ~w_pending[0];
  assign w_selWe   = w_we[w_selPort];
  assign w_selAddr = 64'(w_addr[w_selPort]);

  assign w_issueRd = (r_state == ST_ISSUE) && !w_selWe;
  assign w_issueWr = (r_state == ST_ISSUE) &&  w_selWe;

  assign w_complete = ((r_state == ST_WAIT_RD) && (i_read_ready  == READY_VALID)) ||
                      ((r_state == ST_WAIT_WR) && (i_write_ready == READY_VALID));
  assign w_clear       = {w_complete & w_selPort, w_complete & ~w_selPort};
  assign w_pendingLeft = w_pending & ~w_clear;

  // Request fields are driven live during the ISSUE pulse and then held.
  assign o_kernel_en        = (r_state == ST_STEP);
  assign o_done             = (r_state == ST_DONE);
  assign o_read_enable      = w_issueRd;
  assign o_write_enable     = w_issueWr;
  assign o_read_addr        = w_issueRd ? byteAddr(i_read_base, w_selAddr)  : r_readAddr;
  assign o_read_size_output = w_issueRd ? i_read_size_input                 : r_readSize;
  assign o_write_addr       = w_issueWr ? byteAddr(i_write_base, w_selAddr) : r_writeAddr;
  assign o_write_size       = w_issueWr ? i_read_size_input                 : r_writeSize;
  assign o_write_data       = w_issueWr ? w_d[w_selPort]                    : r_writeData;
  assign o_rsp_q            = r_rspQ;
  assign o_err              = r_err;
  assign o_access_count     = r_accessCount;

  // Hold registers for the host request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readAddr  <= '0;
      r_readSize  <= '0;
      r_writeAddr <= '0;
      r_writeSize <= '0;
      r_writeData <= '0;
    end else begin
      if (w_issueRd) begin
        r_readAddr <= o_read_addr;
        r_readSize <= o_read_size_output;
      end
      if (w_issueWr) begin
        r_writeAddr <= o_write_addr;
        r_writeSize <= o_write_size;
        r_writeData <= o_write_data;
      end
    end
  end

  // Main sequencer. Ready seen in ISSUE is never looked at; only WAIT cycles
  // count toward completion or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_kdone       <= 1'b0;
      r_waitCnt     <= '0;
      r_err         <= 1'b0;
      r_accessCount <= '0;
      r_rspQ        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_accessCount <= '0;
            r_state       <= ST_STEP;
          end
        end
        ST_STEP: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_kdone <= i_kernel_done;
          if (i_req_ce != 2'b00)
            r_state <= ST_ISSUE;
          else if (i_kernel_done)
            r_state <= ST_DONE;
          else
            r_state <= ST_STEP;
        end
        ST_ISSUE: begin
          r_waitCnt <= '0;
          r_state   <= w_selWe ? ST_WAIT_WR : ST_WAIT_RD;
        end
        ST_WAIT_RD, ST_WAIT_WR: begin
          if (w_complete) begin
            if ((r_state == ST_WAIT_RD) && w_selPort)
              r_rspQ[DATA_WID +: DATA_WID] <= i_read_data;
            else if (r_state == ST_WAIT_RD)
              r_rspQ[0 +: DATA_WID] <= i_read_data;
            if (r_accessCount != 32'hFFFF_FFFF)
              r_accessCount <= r_accessCount + 32'd1;
            if (w_pendingLeft != 2'b00)
              r_state <= ST_ISSUE;
            else if (r_kdone)
              r_state <= ST_DONE;
            else
              r_state <= ST_STEP;
          end else if (r_waitCnt == 32'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_HALT;
          end else begin
            r_waitCnt <= r_waitCnt + 32'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Scoreboard bench: expected host requests and done pulses are queued as
// each scenario is set up; a monitor pops and compares whenever the DUT
// presents one. A kernel model feeds step requests on each kernel_en and a
// host model answers requests (including deliberately ignored ready values).
module tb_mem_port_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_start = 1'b0;
  logic            i_kernel_done = 1'b0;
  logic            o_kernel_en;
  logic [1:0]      i_req_ce = '0;
  logic [1:0]      i_req_we = '0;
  logic [2*AW-1:0] i_req_addr = '0;
  logic [2*DW-1:0] i_req_d = '0;
  logic [2*DW-1:0] o_rsp_q;
  logic [63:0]     i_read_base = 64'h1000;
  logic [63:0]     i_write_base = 64'h2000;
  logic [63:0]     i_read_size_input = 64'h40;
  logic            o_read_enable;
  logic            o_write_enable;
  logic [63:0]     o_read_addr;
  logic [63:0]     o_write_addr;
  logic [63:0]     o_read_size_output;
  logic [63:0]     o_write_size;
  logic [DW-1:0]   o_write_data;
  logic [DW-1:0]   i_read_data = '0;
  logic [63:0]     i_read_ready = '0;
  logic [63:0]     i_write_ready = '0;
  logic            o_done;
  logic            o_err;
  logic [31:0]     o_access_count;

  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] size;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    ce;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          kdone;
  } step_t;

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_DONE  = 2;

  exp_t  expQ[$];
  step_t stepQ[$];
  int    nCompared = 0;
  int    nMismatched = 0;
  int    kenCount = 0;
  int    doneCount = 0;
  bit    hostAuto = 1'b1;
  bit    hostWithhold = 1'b0;

  mem_port_arbiter #(
    .ADDR_WID (AW),
    .DATA_WID (DW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_start            (i_start),
    .i_kernel_done      (i_kernel_done),
    .o_kernel_en        (o_kernel_en),
    .i_req_ce           (i_req_ce),
    .i_req_we           (i_req_we),
    .i_req_addr         (i_req_addr),
    .i_req_d            (i_req_d),
    .o_rsp_q            (o_rsp_q),
    .i_read_base        (i_read_base),
    .i_write_base       (i_write_base),
    .i_read_size_input  (i_read_size_input),
    .o_read_enable      (o_read_enable),
    .o_write_enable     (o_write_enable),
    .o_read_addr        (o_read_addr),
    .o_write_addr       (o_write_addr),
    .o_read_size_output (o_read_size_output),
    .o_write_size       (o_write_size),
    .o_write_data       (o_write_data),
    .i_read_data        (i_read_data),
    .i_read_ready       (i_read_ready),
    .i_write_ready      (i_write_ready),
    .o_done             (o_done),
    .o_err              (o_err),
    .o_access_count     (o_access_count)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkEvent(input int kind, input logic [63:0] addr,
                            input logic [63:0] size, input logic [31:0] data);
    exp_t e;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL unexpected event: kind %0d addr 0x%0h data 0x%0h, expected none",
               kind, addr, data);
    end else begin
      e = expQ.pop_front();
      checkOutput("event kind", 64'(kind), 64'(e.kind));
      if (e.kind == K_READ) begin
        checkOutput("read_addr", addr, e.addr);
        checkOutput("read_size_output", size, e.size);
      end else if (e.kind == K_WRITE) begin
        checkOutput("write_addr", addr, e.addr);
        checkOutput("write_data", 64'(data), 64'(e.data));
        checkOutput("write_size", size, e.size);
      end else begin
        checkOutput("access_count at done", 64'(data), 64'(e.data));
      end
    end
  endtask

  // Monitor: scoreboard side, samples mid-cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (o_read_enable)  checkEvent(K_READ, o_read_addr, o_read_size_output, 32'd0);
        if (o_write_enable) checkEvent(K_WRITE, o_write_addr, o_write_size, o_write_data);
        if (o_done) begin
          doneCount++;
          checkEvent(K_DONE, 64'd0, 64'd0, o_access_count);
        end
      end
    end
  end

  // Kernel model: each step pulse presents the next queued request set,
  // held through the CAPTURE cycle that follows.
  initial begin : kernelModel
    step_t s;
    forever begin
      @(negedge clk);
      if (!reset && o_kernel_en) begin
        kenCount++;
        if (stepQ.size() > 0) s = stepQ.pop_front();
        else s = '{2'b00, 2'b00, '0, '0, '0, '0, 1'b1};
        i_req_ce      = s.ce;
        i_req_we      = s.we;
        i_req_addr    = {s.a1, s.a0};
        i_req_d       = {s.d1, s.d0};
        i_kernel_done = s.kdone;
      end
    end
  end

  // Host model. Reads: ready=1 with junk during ISSUE, ready=2 with junk in
  // the first WAIT cycle, then ready=1 with the real data. Read data is
  // the low address word XOR 0xA5A50000.
  initial begin : hostModel
    logic [63:0] rdAddr;
    forever begin
      @(negedge clk);
      while (hostAuto && !hostWithhold && !reset && (o_read_enable || o_write_enable)) begin
        if (o_read_enable) begin
          rdAddr       = o_read_addr;
          i_read_ready = 64'd1;
          i_read_data  = 32'hBAD0_BAD0;
          @(negedge clk);
          i_read_ready = 64'd2;
          i_read_data  = 32'hBAD1_BAD1;
          @(negedge clk);
          i_read_ready = 64'd1;
          i_read_data  = rdAddr[31:0] ^ 32'hA5A5_0000;
          @(negedge clk);
          i_read_ready = 64'd0;
          i_read_data  = '0;
        end else begin
          @(negedge clk);
          i_write_ready = 64'd1;
          @(negedge clk);
          i_write_ready = 64'd0;
        end
      end
    end
  end

  task automatic addStep(input logic [1:0] ce, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic kdone);
    step_t s;
    s.ce = ce; s.we = we; s.a0 = a0; s.a1 = a1; s.d0 = d0; s.d1 = d1; s.kdone = kdone;
    stepQ.push_back(s);
  endtask

  task automatic expRead(input logic [63:0] addr, input logic [63:0] size);
    exp_t e;
    e.kind = K_READ; e.addr = addr; e.size = size; e.data = '0;
    expQ.push_back(e);
  endtask

  task automatic expWrite(input logic [63:0] addr, input logic [31:0] data,
                          input logic [63:0] size);
    exp_t e;
    e.kind = K_WRITE; e.addr = addr; e.size = size; e.data = data;
    expQ.push_back(e);
  endtask

  task automatic expDone(input logic [31:0] count);
    exp_t e;
    e.kind = K_DONE; e.addr = '0; e.size = '0; e.data = count;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic waitForDone(input int budget);
    int target;
    bit seen;
    target = doneCount + 1;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (doneCount >= target) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done pulse seen", 64'(seen), 64'd1);
  endtask

  task automatic waitForEnable(input bit isWrite, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (isWrite ? o_write_enable : o_read_enable) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(isWrite ? "write_enable seen" : "read_enable seen", 64'(seen), 64'd1);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " kernel_en"},        64'(o_kernel_en),    64'd0);
    checkOutput({tag, " read_enable"},      64'(o_read_enable),  64'd0);
    checkOutput({tag, " write_enable"},     64'(o_write_enable), 64'd0);
    checkOutput({tag, " done"},             64'(o_done),         64'd0);
    checkOutput({tag, " err"},              64'(o_err),          64'd0);
    checkOutput({tag, " read_addr"},        o_read_addr,         64'd0);
    checkOutput({tag, " write_addr"},       o_write_addr,        64'd0);
    checkOutput({tag, " read_size_output"}, o_read_size_output,  64'd0);
    checkOutput({tag, " write_size"},       o_write_size,        64'd0);
    checkOutput({tag, " write_data"},       64'(o_write_data),   64'd0);
    checkOutput({tag, " rsp_q"},            64'(o_rsp_q),        64'd0);
    checkOutput({tag, " access_count"},     64'(o_access_count), 64'd0);
  endtask

  initial begin : stimulus
    int ken0;
    int done0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkResetState("initial");

    // Three idle steps, the last one reporting kernel_done.
    ken0 = kenCount;
    addStep(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    addStep(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    addStep(2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    expDone(32'd0);
    applyStimulus();
    waitForDone(100);
    checkOutput("idle run kernel_en pulses", 64'(kenCount - ken0), 64'd3);

    // Port 0 read addr 5, port 1 write 0xDEAD to addr 7 in one step.
    ken0 = kenCount;
    addStep(2'b11, 2'b10, 14'd5, 14'd7, 32'd0, 32'hDEAD, 1'b1);
    expRead(64'h1014, 64'h40);
    expWrite(64'h201C, 32'hDEAD, 64'h40);
    expDone(32'd2);
    applyStimulus();
    waitForDone(100);
    checkOutput("mixed step kernel_en pulses", 64'(kenCount - ken0), 64'd1);
    checkOutput("rsp_q port0 after read", 64'(o_rsp_q[31:0]), 64'hA5A5_1014);
    checkOutput("rsp_q port1 untouched", 64'(o_rsp_q[63:32]), 64'd0);
    checkOutput("access_count after mixed", 64'(o_access_count), 64'd2);

    // Read step without done, then a same-address write pair with done.
    ken0 = kenCount;
    addStep(2'b01, 2'b00, 14'd0, 14'd0, 32'd0, 32'd0, 1'b0);
    addStep(2'b11, 2'b11, 14'd3, 14'd3, 32'h11, 32'h22, 1'b1);
    expRead(64'h1000, 64'h40);
    expWrite(64'h200C, 32'h11, 64'h40);
    expWrite(64'h200C, 32'h22, 64'h40);
    expDone(32'd3);
    applyStimulus();
    waitForDone(150);
    checkOutput("two-step kernel_en pulses", 64'(kenCount - ken0), 64'd2);
    checkOutput("rsp_q port0 second read", 64'(o_rsp_q[31:0]), 64'hA5A5_1000);

    // Port 1 read at the top word address with a base that wraps 2^64.
    i_read_base = 64'hFFFF_FFFF_FFFF_0010;
    addStep(2'b10, 2'b00, 14'd0, 14'h3FFF, 32'd0, 32'd0, 1'b1);
    expRead(64'h0000_0000_0000_000C, 64'h40);
    expDone(32'd1);
    applyStimulus();
    waitForDone(100);
    checkOutput("rsp_q port1 wrapped read", 64'(o_rsp_q[63:32]), 64'hA5A5_000C);
    checkOutput("rsp_q port0 held", 64'(o_rsp_q[31:0]), 64'hA5A5_1000);
    i_read_base = 64'h1000;

    // Host never answers a read: timeout after TMO WAIT cycles, then HALT.
    hostWithhold = 1'b1;
    addStep(2'b01, 2'b00, 14'd1, 14'd0, 32'd0, 32'd0, 1'b0);
    expRead(64'h1004, 64'h40);
    applyStimulus();
    waitForEnable(1'b0, 100);
    repeat (TMO) @(negedge clk);
    checkOutput("err before timeout", 64'(o_err), 64'd0);
    @(negedge clk);
    checkOutput("err at timeout", 64'(o_err), 64'd1);
    ken0  = kenCount;
    done0 = doneCount;
    repeat (20) @(negedge clk);
    checkOutput("kernel_en after halt", 64'(kenCount - ken0), 64'd0);
    checkOutput("done after halt", 64'(doneCount - done0), 64'd0);
    checkOutput("read_enable in halt", 64'(o_read_enable), 64'd0);
    checkOutput("err sticky", 64'(o_err), 64'd1);
    applyReset();
    stepQ.delete();
    hostWithhold = 1'b0;
    checkResetState("after halt reset");

    // Reset during WAIT_WR; write_ready arrives the cycle after reset.
    hostAuto = 1'b0;
    addStep(2'b01, 2'b01, 14'd9, 14'd0, 32'h55, 32'd0, 1'b1);
    expWrite(64'h2024, 32'h55, 64'h40);
    applyStimulus();
    waitForEnable(1'b1, 100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_write_ready = 64'd1;
    @(negedge clk);
    i_write_ready = 64'd0;
    checkResetState("after abort");
    ken0  = kenCount;
    done0 = doneCount;
    repeat (5) @(negedge clk);
    checkOutput("access_count after late ready", 64'(o_access_count), 64'd0);
    checkOutput("done after abort", 64'(doneCount - done0), 64'd0);
    checkOutput("kernel_en after abort", 64'(kenCount - ken0), 64'd0);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d compared so far", nCompared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
